event_log_formatter: RTL and testbench

- Consumer end of the event valid/ready interface driven by the event generators (demo and timestamping pipeline).
- Accepts one event record {id, start_ts, end_ts, delta}.
- Serializes the record as an ASCII hex text line onto a byte-wide valid/ready stream that feeds the UART TX.
- Sits between the event source and uart_tx. Backpressure from the UART is propagated to the event source; events are never dropped.

---
 rtl/event_log_formatter_if.sv | 29 ++
 rtl/event_log_formatter.sv | 154 +++++++++++++++
 tb/tb_event_log_formatter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_log_formatter_if.sv
// Event record in / ASCII byte out bundle for the event log formatter.
// Ports: in_* record handshake, tx_* byte stream, busy status.
interface event_log_formatter_if #(
    parameter int ID_W = 16,
    parameter int TS_W = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [ID_W-1:0] in_id;
    logic [TS_W-1:0] in_start_ts;
    logic [TS_W-1:0] in_end_ts;
    logic [TS_W-1:0] in_delta;
    logic            tx_valid;
    logic            tx_ready;
    logic [7:0]      tx_data;
    logic            busy;

    modport master (
        output in_valid, in_id, in_start_ts,
        output in_end_ts, in_delta, tx_ready,
        input  in_ready, tx_valid, tx_data, busy
    );

    modport slave (
        input  in_valid, in_id, in_start_ts,
        input  in_end_ts, in_delta, tx_ready,
        output in_ready, tx_valid, tx_data, busy
    );
endinterface

// File: rtl/event_log_formatter.sv
// Prints one event record per line as uppercase hex text on a byte stream.
// Ports: clk, rst_n (async, active low), bus (slave: in_* / tx_* / busy).
// Option: define LOGGER_DELTA_CHECK_EN to append " !" when end-start != delta.
module event_log_formatter #(
    parameter int ID_W = 16,
    parameter int TS_W = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    event_log_formatter_if.slave bus
);
    localparam int MW = (ID_W > TS_W) ? ID_W : TS_W;
    localparam int NW = $clog2(MW / 4 + 1);
    localparam logic [NW-1:0] ID_LAST = NW'(ID_W / 4 - 1);
    localparam logic [NW-1:0] TS_LAST = NW'(TS_W / 4 - 1);

    typedef enum logic [3:0] {
        IDLE, ID, SEP, START, END, DELTA, BSP, BANG, CR, LF
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    state_t          w_tail;
    logic            r_armed;
    logic [ID_W-1:0] r_id;
    logic [TS_W-1:0] r_start;
    logic [TS_W-1:0] r_end;
    logic [TS_W-1:0] r_delta;
    logic [NW-1:0]   r_nib;
    logic [NW-1:0]   w_nib_nx;
    logic [1:0]      r_fld;
    logic [1:0]      w_fld_nx;
    logic            w_cap;
    logic            w_hs;
    logic [MW-1:0]   w_field;
    logic [3:0]      w_nibble;
    logic [7:0]      w_hex;

    // in_ready stays low until the first edge after reset release.
    assign bus.in_ready = r_armed && (r_state == IDLE);
    assign bus.tx_valid = (r_state != IDLE);
    assign bus.busy     = (r_state != IDLE);
    assign w_hs         = bus.tx_valid && bus.tx_ready;

`ifdef LOGGER_DELTA_CHECK_EN
    logic r_mis;
    assign w_tail = r_mis ? BSP : CR;
`else
    assign w_tail = CR;
`endif

    always_comb begin
        w_field = '0;
        unique case (r_state)
            ID:      w_field = MW'(r_id);
            START:   w_field = MW'(r_start);
            END:     w_field = MW'(r_end);
            DELTA:   w_field = MW'(r_delta);
            default: w_field = '0;
        endcase
        w_nibble = w_field[{r_nib, 2'b00} +: 4];
        w_hex    = (w_nibble < 4'd10) ? {4'h3, w_nibble}
                                      : 8'h37 + {4'h0, w_nibble};
    end

    always_comb begin
        bus.tx_data = 8'h00;
        unique case (r_state)
            ID, START, END, DELTA: bus.tx_data = w_hex;
            SEP, BSP:              bus.tx_data = 8'h20;
            BANG:                  bus.tx_data = 8'h21;
            CR:                    bus.tx_data = 8'h0D;
            LF:                    bus.tx_data = 8'h0A;
            default:               bus.tx_data = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_nib_nx   = r_nib;
        w_fld_nx   = r_fld;
        w_cap      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    w_cap      = 1'b1;
                    w_state_nx = ID;
                    w_nib_nx   = ID_LAST;
                end
            end
            ID, START, END, DELTA: begin
                if (w_hs) begin
                    if (r_nib != '0) begin
                        w_nib_nx = r_nib - NW'(1);
                    end else if (r_state == DELTA) begin
                        w_state_nx = w_tail;
                    end else begin
                        w_state_nx = SEP;
                        if (r_state == ID) w_fld_nx = 2'd0;
                    end
                end
            end
            // r_fld remembers which timestamp field follows this separator.
            SEP: begin
                if (w_hs) begin
                    w_nib_nx = TS_LAST;
                    w_fld_nx = r_fld + 2'd1;
                    if (r_fld == 2'd0)      w_state_nx = START;
                    else if (r_fld == 2'd1) w_state_nx = END;
                    else                    w_state_nx = DELTA;
                end
            end
            BSP:  if (w_hs) w_state_nx = BANG;
            BANG: if (w_hs) w_state_nx = CR;
            CR:   if (w_hs) w_state_nx = LF;
            LF:   if (w_hs) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_armed <= 1'b0;
            r_nib   <= '0;
            r_fld   <= '0;
            r_id    <= '0;
            r_start <= '0;
            r_end   <= '0;
            r_delta <= '0;
        end else begin
            r_state <= w_state_nx;
            r_armed <= 1'b1;
            r_nib   <= w_nib_nx;
            r_fld   <= w_fld_nx;
            if (w_cap) begin
                r_id    <= bus.in_id;
                r_start <= bus.in_start_ts;
                r_end   <= bus.in_end_ts;
                r_delta <= bus.in_delta;
            end
        end
    end

`ifdef LOGGER_DELTA_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mis <= 1'b0;
        end else if (w_cap) begin
            r_mis <= (bus.in_end_ts - bus.in_start_ts) != bus.in_delta;
        end
    end
`endif
endmodule

// File: tb/tb_event_log_formatter.sv
// Bench for event_log_formatter: random records and tx_ready patterns
// checked against a text-line model; honours LOGGER_DELTA_CHECK_EN.
`timescale 1ns/1ps
module tb_event_log_formatter;
    localparam int ID_W = 16;
    localparam int TS_W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    event_log_formatter_if #(.ID_W(ID_W), .TS_W(TS_W)) bus ();

    event_log_formatter #(.ID_W(ID_W), .TS_W(TS_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    byte unsigned exp_q[$];
    byte unsigned got_q[$];

    task automatic push_hex(input logic [63:0] v, input int n);
        logic [3:0] d;
        for (int i = n - 1; i >= 0; i--) begin
            d = v[i*4 +: 4];
            exp_q.push_back(d < 10 ? 8'h30 + d : 8'h41 + (d - 10));
        end
    endtask

    task automatic build_exp(input logic [15:0] id,
                             input logic [63:0] s, e, d);
        exp_q.delete();
        push_hex(64'(id), ID_W / 4);
        exp_q.push_back(8'h20);
        push_hex(s, TS_W / 4);
        exp_q.push_back(8'h20);
        push_hex(e, TS_W / 4);
        exp_q.push_back(8'h20);
        push_hex(d, TS_W / 4);
`ifdef LOGGER_DELTA_CHECK_EN
        if (e - s != d) begin
            exp_q.push_back(8'h20);
            exp_q.push_back(8'h21);
        end
`endif
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic byte unsigned gq(input int i);
        return (i >= 0 && i < got_q.size()) ? got_q[i] : 8'h00;
    endfunction

    function automatic byte unsigned eq(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 8'h00;
    endfunction

    // Called at a negedge; returns at the negedge presenting the last byte.
    // mode 0: ready high, 1: toggle + 20-cycle stall at byte 10, 2: random.
    task automatic run_line(input logic [15:0] id,
                            input logic [63:0] s, e, d,
                            input int mode, input int stop_after,
                            input bit keep_valid,
                            output int wait_cyc, output int line_cyc,
                            output int gaps);
        bit prev_stall;
        bit done;
        bit rdy;
        byte unsigned prev_d;
        int stretch;
        bus.in_id = id;
        bus.in_start_ts = s;
        bus.in_end_ts = e;
        bus.in_delta = d;
        bus.in_valid = 1'b1;
        wait_cyc = 0;
        line_cyc = 0;
        gaps = 0;
        got_q.delete();
        while (!bus.in_ready && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL capture_timeout in_ready=%b required 1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = keep_valid;
        bus.in_id = 16'($urandom);
        bus.in_start_ts = {$urandom, $urandom};
        bus.in_end_ts = {$urandom, $urandom};
        bus.in_delta = {$urandom, $urandom};
        prev_stall = 1'b0;
        prev_d = 8'h00;
        stretch = 0;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            line_cyc++;
            if (prev_stall) begin
                n_cmp++;
                if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_d) begin
                    n_err++;
                    $display("FAIL stall_hold valid=%b data=%h required 1/%h",
                             bus.tx_valid, bus.tx_data, prev_d);
                end
            end
            if (!bus.tx_valid) gaps++;
            if (mode == 0) begin
                rdy = 1'b1;
            end else if (mode == 1) begin
                if (got_q.size() == 10 && stretch < 20) begin
                    rdy = 1'b0;
                    stretch++;
                end else begin
                    rdy = (line_cyc % 2) == 1;
                end
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            bus.tx_ready = rdy;
            prev_stall = bus.tx_valid && !rdy;
            prev_d = bus.tx_data;
            if (bus.tx_valid && rdy) begin
                got_q.push_back(bus.tx_data);
                if (bus.tx_data == 8'h0A || got_q.size() == stop_after)
                    done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL line_timeout bytes=%0d required %0d",
                     got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.tx_ready = 1'b0;
        bus.in_id = '0;
        bus.in_start_ts = '0;
        bus.in_end_ts = '0;
        bus.in_delta = '0;
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_ready got=%b required 0", bus.in_ready);
        end
        n_cmp++;
        if (bus.tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_tx_valid got=%b required 0", bus.tx_valid);
        end
        n_cmp++;
        if (bus.tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_tx_data got=%h required 00", bus.tx_data);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy got=%b required 0", bus.busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL release_in_ready got=%b required 0", bus.in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL first_edge_in_ready got=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        int w, lc, g, k;
        build_exp(16'h0001, 64'h2FAF080, 64'h2FAF468, 64'h3E8);
        run_line(16'h0001, 64'h2FAF080, 64'h2FAF468, 64'h3E8, 0, 0, 0, w, lc, g);
        k = first_diff();
        n_cmp++;
        if (k != -1) begin
            n_err++;
            $display("FAIL basic_line at %0d got=%h required %h (len %0d/%0d)",
                     k, gq(k), eq(k), got_q.size(), exp_q.size());
        end
        n_cmp++;
        if (got_q.size() != 57) begin
            n_err++;
            $display("FAIL basic_len got=%0d required 57", got_q.size());
        end
        n_cmp++;
        if (w != 0 || g != 0 || lc != 57) begin
            n_err++;
            $display("FAIL basic_timing wait=%0d gaps=%0d cycles=%0d required 0/0/57",
                     w, g, lc);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_after_lf in_ready=%b busy=%b required 1/0",
                     bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_backpressure();
        int w, lc, g, k;
        build_exp(16'h0001, 64'h2FAF080, 64'h2FAF468, 64'h3E8);
        run_line(16'h0001, 64'h2FAF080, 64'h2FAF468, 64'h3E8, 1, 0, 0, w, lc, g);
        k = first_diff();
        n_cmp++;
        if (k != -1) begin
            n_err++;
            $display("FAIL backpressure_line at %0d got=%h required %h (len %0d/%0d)",
                     k, gq(k), eq(k), got_q.size(), exp_q.size());
        end
        @(negedge clk);
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int w, lc, g, k;
        build_exp(16'h0001, 64'h10, 64'h20, 64'h10);
        run_line(16'h0001, 64'h10, 64'h20, 64'h10, 0, 0, 1, w, lc, g);
        k = first_diff();
        n_cmp++;
        if (k != -1) begin
            n_err++;
            $display("FAIL b2b_first at %0d got=%h required %h", k, gq(k), eq(k));
        end
        build_exp(16'h0002, 64'h30, 64'h50, 64'h20);
        run_line(16'h0002, 64'h30, 64'h50, 64'h20, 0, 0, 0, w, lc, g);
        n_cmp++;
        if (w != 1) begin
            n_err++;
            $display("FAIL b2b_gap got=%0d cycles required 1", w);
        end
        k = first_diff();
        n_cmp++;
        if (k != -1) begin
            n_err++;
            $display("FAIL b2b_second at %0d got=%h required %h", k, gq(k), eq(k));
        end
        @(negedge clk);
    endtask

    task automatic test_extremes();
        int w, lc, g, k;
        build_exp(16'hFFFF, 64'hFFFFFFFFFFFFFC18, 64'h0, 64'h3E8);
        run_line(16'hFFFF, 64'hFFFFFFFFFFFFFC18, 64'h0, 64'h3E8, 2, 0, 0, w, lc, g);
        k = first_diff();
        n_cmp++;
        if (k != -1 || got_q.size() != 57) begin
            n_err++;
            $display("FAIL extremes_line at %0d got=%h required %h (len %0d/57)",
                     k, gq(k), eq(k), got_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_delta_mismatch();
        int w, lc, g, k, len;
`ifdef LOGGER_DELTA_CHECK_EN
        len = 59;
`else
        len = 57;
`endif
        build_exp(16'h0003, 64'h0, 64'h3E8, 64'h3E7);
        run_line(16'h0003, 64'h0, 64'h3E8, 64'h3E7, 0, 0, 0, w, lc, g);
        k = first_diff();
        n_cmp++;
        if (k != -1) begin
            n_err++;
            $display("FAIL mismatch_line at %0d got=%h required %h", k, gq(k), eq(k));
        end
        n_cmp++;
        if (got_q.size() != len) begin
            n_err++;
            $display("FAIL mismatch_len got=%0d required %0d", got_q.size(), len);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midline();
        int w, lc, g, k;
        build_exp(16'h0A0B, 64'h1234, 64'h5678, 64'h4444);
        run_line(16'h0A0B, 64'h1234, 64'h5678, 64'h4444, 0, 20, 0, w, lc, g);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.tx_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.busy !== 1'b0 || bus.tx_data !== 8'h00) begin
            n_err++;
            $display("FAIL midline_reset v=%b r=%b b=%b d=%h required 0/0/0/00",
                     bus.tx_valid, bus.in_ready, bus.busy, bus.tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midline_rearm in_ready=%b required 1", bus.in_ready);
        end
        build_exp(16'h0C0D, 64'h99, 64'hAA, 64'h11);
        run_line(16'h0C0D, 64'h99, 64'hAA, 64'h11, 0, 0, 0, w, lc, g);
        k = first_diff();
        n_cmp++;
        if (k != -1) begin
            n_err++;
            $display("FAIL midline_new_line at %0d got=%h required %h", k, gq(k), eq(k));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int w, lc, g, k;
        logic [15:0] id;
        logic [63:0] s, e, d;
        for (int t = 0; t < 10; t++) begin
            id = 16'($urandom);
            s = {$urandom, $urandom};
            e = {$urandom, $urandom};
            d = (t % 2 == 0) ? e - s : {$urandom, $urandom};
            if (t == 3) begin
                id = '0;
                s = '0;
                e = '0;
                d = '0;
            end
            build_exp(id, s, e, d);
            run_line(id, s, e, d, (t % 3 == 0) ? 1 : 2, 0, (t % 4 == 1), w, lc, g);
            k = first_diff();
            n_cmp++;
            if (k != -1) begin
                n_err++;
                $display("FAIL random_line%0d at %0d got=%h required %h (len %0d/%0d)",
                         t, k, gq(k), eq(k), got_q.size(), exp_q.size());
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_extremes();
        test_delta_mismatch();
        test_reset_midline();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
